alu_e: RTL and testbench
========================

# alu_e

Adder-and-logic stage with the E (carry/extend) flip-flop, sitting directly upstream of the accumulator register. It accepts an operation request and operands (AC, DR, INPR), then produces the next accumulator value on RESULT. It pulses DONE, which the control unit wires straight to the accumulator's LD input. Single-cycle operations complete in one clock; an optional iterative multiply takes 16 extra cycles.

## Interface
- No parameters; datapath width fixed at 16 bits (INPR 8 bits).
- CLK  input  1  rising-edge clock.
- CLR  input  1  synchronous, active-low reset.
- START  input  1  request strobe; sampled on CLK rising edge.
- OP  input  3  operation code, sampled with START.
- AC  input  16  current accumulator value, sampled with START.
- DR  input  16  data register operand, sampled with START.
- INPR  input  8  input register operand, sampled with START.
- CLE  input  1  clear E.
- CME  input  1  complement E.
- RESULT  output  16  next accumulator value; feeds accumulator Data.
- E  output  1  E flip-flop.
- DONE  output  1  one-cycle pulse; RESULT valid while high; feeds accumulator LD.
- BUSY  output  1  high while a multiply iterates.

## Operation
- States: IDLE, RUN, FIN.
- START is accepted only in IDLE or FIN. START in RUN is ignored, with no queueing.
- OP encodings (A = captured AC, D = captured DR):
  - 000 AND: A & D.
  - 001 ADD: {E, RESULT} = A + D (17-bit sum; carry to E).
  - 010 LDA: D.
  - 011 INP: {A[15:8], INPR}.
  - 100 CMA: ~A.
  - 101 CIR: {E, RESULT} = {A[0], E_old, A[15:1]}.
  - 110 CIL: {E, RESULT} = {A[15], A[14:0], E_old}.
  - 111 MUL: see Configuration.
- Single-cycle ops: IDLE/FIN --START--> FIN. RESULT and E update on that edge.
- FIN with no START goes to IDLE.
- E is unchanged by AND, LDA, INP, CMA.
- CLE/CME act only in IDLE or FIN, and only when START is low. CLE has priority over CME. Neither touches RESULT or DONE.
- RESULT holds its value between operations. The accumulator ignores it unless DONE is high.

## Timing
- Reset (CLR low at an edge): RESULT = 0, E = 0, DONE = 0, BUSY = 0, state IDLE, multiply counter 0.
- Reset overrides START, CLE and CME.
- Reset during RUN aborts the multiply; no DONE is produced.
- Single-cycle op with START at edge t: DONE is high during cycle t+1 only.
- Back-to-back: START held high every cycle gives one result per cycle, with DONE continuously high.
- BUSY is low for all single-cycle ops.
- Operands are captured at the START edge. Changes to AC, DR or INPR afterwards are ignored until the next accepted START.

## Configuration
- Macro: ALU_MUL_EN.
- Defined:
  - OP=111 multiplies unsigned A × D by shift-and-add, one multiplier bit per cycle.
  - START edge t goes to RUN; BUSY is high in cycles t+1..t+16; FIN (DONE high) in cycle t+17, with BUSY low there.
  - RESULT = low 16 bits of the product.
  - E = OR of the high 16 bits (overflow flag).
  - RESULT keeps its previous value during RUN.
- Undefined:
  - OP=111 is a single-cycle NOP: RESULT = A, E unchanged, DONE in cycle t+1.
  - RUN is unreachable and BUSY is tied low.

## Test plan
- Reset: CLR low for 2 cycles with START high -> RESULT = 0x0000, E = 0, DONE = 0, BUSY = 0.
- ADD: AC = 0xFFFF, DR = 0x0001, OP = 001 -> next cycle RESULT = 0x0000, E = 1, DONE pulse of exactly one cycle.
- Rotate: E = 1, AC = 0x0001, OP = 101 -> RESULT = 0x8000, E = 1. Then AC = 0x8000, E = 0, OP = 110 -> RESULT = 0x0000, E = 1.
- E control: E = 1, CLE and CME both high, START low -> E = 0. Next cycle CME alone -> E = 1, DONE stays low.
- Multiply (ALU_MUL_EN defined): AC = 0x0012, DR = 0x0034 -> BUSY high 16 cycles, DONE on cycle 17, RESULT = 0x03A8, E = 0. A START pulse mid-run is ignored.
- Multiply overflow, then reset abort: AC = 0x0100, DR = 0x0100 -> RESULT = 0x0000, E = 1. Repeat with CLR low at cycle 8 -> no DONE, E = 0, state IDLE.

Source files
------------

// File: rtl/alu_e_if.sv
// alu_e_if: operation request / result bundle between the control unit and alu_e.
// master = control unit side (drives request, operands and E control),
// slave  = alu_e (drives RESULT, E, DONE, BUSY).
interface alu_e_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] ac;
    logic [15:0] dr;
    logic [7:0]  inpr;
    logic        cle;
    logic        cme;
    logic [15:0] result;
    logic        e;
    logic        done;
    logic        busy;

    modport master (
        output start, op, ac, dr, inpr, cle, cme,
        input  result, e, done, busy
    );

    modport slave (
        input  start, op, ac, dr, inpr, cle, cme,
        output result, e, done, busy
    );
endinterface

// File: rtl/alu_e.sv
// alu_e: adder-and-logic stage with the E (carry/extend) flip-flop, feeding the
// accumulator. DONE drives the accumulator load; RESULT holds between ops.
// Optional feature macro: ALU_MUL_EN enables the 16-cycle shift-and-add multiply
// on OP=111. Without it OP=111 is a single-cycle pass-through of AC.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; CLE/CME act here when START is low
// RUN   | multiply iterating, one multiplier bit per cycle, BUSY high
// FIN   | result cycle, DONE high; a new START is accepted here too
module alu_e (
    input logic   CLK,
    input logic   CLR,
    alu_e_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_INP = 3'b011;
    localparam logic [2:0] OP_CMA = 3'b100;
    localparam logic [2:0] OP_CIR = 3'b101;
    localparam logic [2:0] OP_CIL = 3'b110;

    state_t      state;
    logic [15:0] result_q;
    logic        e_q;
    logic        done_q;
    logic [16:0] sc_nxt;   // {E, RESULT} for a single-cycle op

`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;

    logic        busy_q;
    logic [3:0]  cnt;       // iterations remaining after the current one
    logic [15:0] mcand;
    logic [31:0] prod;      // {partial high, multiplier shifting out low}
    logic [16:0] psum;
    logic [31:0] prod_nxt;

    // One shift-and-add step: add multiplicand to the high half if the current
    // multiplier bit is set, then shift the 33-bit {carry, high, low} right.
    always_comb begin
        psum     = {1'b0, prod[31:16]} + (prod[0] ? {1'b0, mcand} : 17'd0);
        prod_nxt = {psum, prod[15:1]};
    end

    assign bus.busy = busy_q;
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.result = result_q;
    assign bus.e      = e_q;
    assign bus.done   = done_q;

    // Single-cycle op result from the live operands (captured on the START edge).
    always_comb begin
        sc_nxt = {e_q, bus.ac};
        case (bus.op)
            OP_AND: sc_nxt = {e_q, bus.ac & bus.dr};
            OP_ADD: sc_nxt = {1'b0, bus.ac} + {1'b0, bus.dr};
            OP_LDA: sc_nxt = {e_q, bus.dr};
            OP_INP: sc_nxt = {e_q, bus.ac[15:8], bus.inpr};
            OP_CMA: sc_nxt = {e_q, ~bus.ac};
            OP_CIR: sc_nxt = {bus.ac[0], e_q, bus.ac[15:1]};
            OP_CIL: sc_nxt = {bus.ac[15], bus.ac[14:0], e_q};
            default: sc_nxt = {e_q, bus.ac};
        endcase
    end

    // Sequencer, E flip-flop and registered outputs.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state    <= IDLE;
            result_q <= 16'h0000;
            e_q      <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q   <= 1'b0;
            cnt      <= 4'd0;
            mcand    <= 16'h0000;
            prod     <= 32'h0000_0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
`ifdef ALU_MUL_EN
                        if (bus.op == OP_MUL) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            cnt    <= 4'd15;
                            mcand  <= bus.dr;
                            prod   <= {16'h0000, bus.ac};
                        end else
`endif
                        begin
                            state               <= FIN;
                            done_q              <= 1'b1;
                            {e_q, result_q}     <= sc_nxt;
                        end
                    end else begin
                        state <= IDLE;
                        if (bus.cle) begin
                            e_q <= 1'b0;
                        end else if (bus.cme) begin
                            e_q <= ~e_q;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                RUN: begin
                    prod <= prod_nxt;
                    if (cnt == 4'd0) begin
                        state    <= FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= prod_nxt[15:0];
                        e_q      <= |prod_nxt[31:16];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_e.sv
// tb_alu_e: directed bench for alu_e. A table of single-cycle ops runs
// back-to-back with START held high; hand-written sequences cover reset,
// E control, operand capture and (with ALU_MUL_EN) the multiply.
module tb_alu_e;

    logic CLK;
    logic CLR;
    int   checks;
    int   failures;

    alu_e_if bus ();

    alu_e dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] ac;
        logic [15:0] dr;
        logic [7:0]  inpr;
        logic [15:0] r;
        logic        e;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        // E and RESULT start from a known state only once reset has been seen.
        CLR      = 1'b0;
        bus.start = 1'b1;
        bus.op   = 3'b001;
        bus.ac   = 16'hFFFF;
        bus.dr   = 16'h0001;
        bus.inpr = 8'h00;
        bus.cle  = 1'b0;
        bus.cme  = 1'b1;
        tick();
        tick();
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_e", bus.e, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);

        // Make E=1, then reset again with START high to see E cleared.
        CLR = 1'b1;
        tick();
        chk("pre_e", bus.e, 1'b1);
        CLR = 1'b0;
        tick();
        tick();
        chk("rst2_e", bus.e, 1'b0);
        chk("rst2_result", bus.result, 16'h0000);
        chk("rst2_done", bus.done, 1'b0);
        bus.start = 1'b0;
        bus.cme   = 1'b0;
        CLR = 1'b1;
        tick();

        vecs[0]  = '{3'b001, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 1'b1};
        vecs[1]  = '{3'b000, 16'hF0F0, 16'h3C3C, 8'h00, 16'h3030, 1'b1};
        vecs[2]  = '{3'b010, 16'h0000, 16'h1234, 8'h00, 16'h1234, 1'b1};
        vecs[3]  = '{3'b011, 16'hABCD, 16'h0000, 8'h5A, 16'hAB5A, 1'b1};
        vecs[4]  = '{3'b100, 16'h00FF, 16'h0000, 8'h00, 16'hFF00, 1'b1};
        vecs[5]  = '{3'b101, 16'h0001, 16'h0000, 8'h00, 16'h8000, 1'b1};
        vecs[6]  = '{3'b001, 16'h1234, 16'h0001, 8'h00, 16'h1235, 1'b0};
        vecs[7]  = '{3'b110, 16'h8000, 16'h0000, 8'h00, 16'h0000, 1'b1};
        vecs[8]  = '{3'b001, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 1'b0};
        vecs[9]  = '{3'b110, 16'h4001, 16'h0000, 8'h00, 16'h8002, 1'b0};
        vecs[10] = '{3'b101, 16'h0003, 16'h0000, 8'h00, 16'h0001, 1'b1};
        vecs[11] = '{3'b001, 16'h8000, 16'h8000, 8'h00, 16'h0000, 1'b1};
        vecs[12] = '{3'b100, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 1'b1};

        // Back-to-back: START stays high, one result and DONE every cycle.
        for (int i = 0; i < 13; i++) begin
            bus.start = 1'b1;
            bus.op    = vecs[i].op;
            bus.ac    = vecs[i].ac;
            bus.dr    = vecs[i].dr;
            bus.inpr  = vecs[i].inpr;
            tick();
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].r);
            chk($sformatf("vec%0d_e", i), bus.e, vecs[i].e);
            chk($sformatf("vec%0d_done", i), bus.done, 1'b1);
            chk($sformatf("vec%0d_busy", i), bus.busy, 1'b0);
        end

        bus.start = 1'b0;
        tick();
        chk("idle_done", bus.done, 1'b0);
        chk("idle_hold", bus.result, 16'hFFFF);

        // E control: CLE beats CME, then CME alone toggles; DONE stays low.
        bus.cle = 1'b1;
        bus.cme = 1'b1;
        tick();
        chk("cle_e", bus.e, 1'b0);
        chk("cle_done", bus.done, 1'b0);
        bus.cle = 1'b0;
        tick();
        chk("cme_e", bus.e, 1'b1);
        chk("cme_done", bus.done, 1'b0);
        chk("cme_result", bus.result, 16'hFFFF);
        bus.cme = 1'b0;

        // Operands are captured at the START edge only.
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.ac    = 16'h0001;
        bus.dr    = 16'h0001;
        tick();
        bus.start = 1'b0;
        bus.ac    = 16'h5555;
        bus.dr    = 16'h7777;
        chk("cap_result", bus.result, 16'h0002);
        chk("cap_e", bus.e, 1'b0);
        tick();
        chk("cap_hold", bus.result, 16'h0002);
        chk("cap_done_low", bus.done, 1'b0);

`ifdef ALU_MUL_EN
        // 0x12 * 0x34 = 0x03A8; a START mid-run must be ignored.
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.ac    = 16'h0012;
        bus.dr    = 16'h0034;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul_busy%0d", i), bus.busy, 1'b1);
            chk($sformatf("mul_nodone%0d", i), bus.done, 1'b0);
            chk($sformatf("mul_hold%0d", i), bus.result, 16'h0002);
            bus.start = (i == 7);
            bus.op    = 3'b001;
            bus.ac    = 16'hFFFF;
            bus.dr    = 16'h0001;
            tick();
        end
        bus.start = 1'b0;
        chk("mul_done", bus.done, 1'b1);
        chk("mul_busy_fin", bus.busy, 1'b0);
        chk("mul_result", bus.result, 16'h03A8);
        chk("mul_e", bus.e, 1'b0);

        // Overflow multiply started straight from FIN.
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.ac    = 16'h0100;
        bus.dr    = 16'h0100;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("ovf_latency", n, 16);
        chk("ovf_result", bus.result, 16'h0000);
        chk("ovf_e", bus.e, 1'b1);

        // Reset during RUN aborts: no DONE, E cleared, back to IDLE.
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort_busy_pre", bus.busy, 1'b1);
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_e", bus.e, 1'b0);
        chk("abort_result", bus.result, 16'h0000);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) n++;
        end
        chk("abort_no_done", n, 0);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.dr    = 16'hC0DE;
        tick();
        bus.start = 1'b0;
        chk("abort_idle_done", bus.done, 1'b1);
        chk("abort_idle_result", bus.result, 16'hC0DE);
`else
        // OP=111 without the multiplier: single-cycle pass-through of AC.
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.ac    = 16'hBEEF;
        bus.dr    = 16'h0000;
        tick();
        bus.start = 1'b0;
        chk("nop_result", bus.result, 16'hBEEF);
        chk("nop_e", bus.e, 1'b0);
        chk("nop_done", bus.done, 1'b1);
        chk("nop_busy", bus.busy, 1'b0);
        tick();
        chk("nop_done_low", bus.done, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
